sr_mdu_seq: RTL

- Iterative multiply/divide sequencer for the CPU's M-type integer operations.
- Holds no adder of its own: each step time-shares the existing 32-bit combinational ALU by driving its srcA, srcB and oper inputs and sampling its result in the same cycle.
- Sits beside the execute stage. Requests use a valid/ready handshake; results return on a valid/ready response port.

---
 rtl/sr_mdu_seq_if.sv | 23 ++
 rtl/sr_mdu_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sr_mdu_seq_if.sv
// Request/response channel between the execute stage and the iterative MUL/DIV sequencer.
interface sr_mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/sr_mdu_seq.sv
// Iterative MUL / DIVU / REMU sequencer that time-shares the core's 32-bit ALU:
// shift-add multiply (32 steps) and restoring divide (32 compare+subtract pairs).
module sr_mdu_seq #(
  parameter int WIDTH         = 32,
  parameter bit DIV_ZERO_FAST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  sr_mdu_seq_if.slave      mdu,
  output logic             busy,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [2:0]       alu_oper,
  input  logic [WIDTH-1:0] alu_result
);

  // ALU operation codes shared with the CPU core's ALU.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;

  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [4:0]       r_cnt;
  logic [1:0]       r_op;
  logic             r_ge;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_req_div;
  logic             w_fast_zero;
  logic             w_last;
  logic [WIDTH-1:0] w_rem_sh;
  logic             w_carry;
  logic             w_ge;

  assign w_accept    = mdu.req_valid && (r_state == S_IDLE);
  assign w_req_div   = (mdu.req_op == OP_DIVU) || (mdu.req_op == OP_REMU);
  assign w_fast_zero = DIV_ZERO_FAST && w_req_div && (mdu.req_b == '0);
  assign w_last      = (r_cnt == 5'd31);

  // Shifted-out remainder MSB means rem_sh >= 2^32 > dvs, so subtract regardless of SLTU.
  assign w_rem_sh = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_carry  = r_rem[WIDTH-1];
  assign w_ge     = w_carry | ~alu_result[0];

  assign mdu.req_ready   = (r_state == S_IDLE);
  assign mdu.resp_valid  = (r_state == S_DONE);
  assign mdu.resp_result = r_result;
  assign busy            = (r_state != S_IDLE);

  always_comb begin
    w_next   = r_state;
    alu_oper = ALU_ADD;
    alu_srcA = '0;
    alu_srcB = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fast_zero)    w_next = S_DONE;
          else if (w_req_div) w_next = S_DIV_CMP;
          else                w_next = S_MUL;
        end
      end
      S_MUL: begin
        alu_oper = ALU_ADD;
        alu_srcA = r_acc;
        alu_srcB = r_mplier[0] ? r_mcand : '0;
        if (w_last) w_next = S_DONE;
      end
      S_DIV_CMP: begin
        alu_oper = ALU_SLTU;
        alu_srcA = w_rem_sh;
        alu_srcB = r_dvs;
        w_next   = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        if (r_ge) begin
          alu_oper = ALU_SUB;
          alu_srcA = r_rem;
          alu_srcB = r_dvs;
        end
        w_next = w_last ? S_DONE : S_DIV_CMP;
      end
      S_DONE: begin
        if (mdu.resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_ge     <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= mdu.req_op;
            r_cnt <= '0;
            if (w_req_div) begin
              r_rem <= '0;
              r_quo <= mdu.req_a;
              r_dvs <= mdu.req_b;
              if (w_fast_zero)
                r_result <= (mdu.req_op == OP_DIVU) ? '1 : mdu.req_a;
            end else begin
              r_acc    <= '0;
              r_mcand  <= mdu.req_a;
              r_mplier <= mdu.req_b;
            end
          end
        end
        S_MUL: begin
          r_acc    <= alu_result;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (w_last) r_result <= alu_result;
        end
        S_DIV_CMP: begin
          r_rem <= w_rem_sh;
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_ge  <= w_ge;
        end
        S_DIV_SUB: begin
          if (r_ge) r_rem <= alu_result;
          r_cnt <= r_cnt + 5'd1;
          // Final remainder is this step's subtract result, so latch it straight from the ALU.
          if (w_last) begin
            if (r_op == OP_REMU) r_result <= r_ge ? alu_result : r_rem;
            else                 r_result <= r_quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
